mul_wide_sequencer: RTL and testbench
=====================================

Name: mul_wide_sequencer

Overview:
Multi-cycle controller that computes a wide unsigned product by time-sharing a single Multiplier8x8 instance across byte-pair partial products.
- Operand width is 8*N_BYTES; the product takes N_BYTES^2 multiply cycles.
- Sits between a valid/ready producer and consumer in the arithmetic datapath.
- Replaces a wide combinational multiplier where area matters more than throughput.

Parameters:
N_BYTES, 2, operand width in bytes (operand width 8*N_BYTES, product width 16*N_BYTES); legal range 1..4.

Ports:
clk  in  1  single system clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  operand pair on a/b is valid
in_ready  out  1  block can accept an operand pair
a  in  8*N_BYTES  multiplicand, unsigned
b  in  8*N_BYTES  multiplier, unsigned
out_valid  out  1  product on p is valid
out_ready  in  1  consumer accepts p
p  out  16*N_BYTES  product, unsigned
busy  out  1  high while in MUL or DONE

Behaviour:
Interface:
- One clock: clk. Reset rst_n is asynchronous and active-low.

Reset (rst_n low, asynchronous, at any time including mid-operation):
- State goes to IDLE; step counter, operand registers and accumulator clear to 0.
- Outputs during/after reset: in_ready=1, out_valid=0, busy=0, p=0.
- An in-flight operation is discarded with no output.

States:
- IDLE:
  - in_ready=1.
  - Accept on an edge with in_valid && in_ready: latch a, b; clear accumulator; step=0; go to MUL.
- MUL:
  - in_ready=0, busy=1.
  - Step s maps to i = s / N_BYTES (a byte index) and j = s % N_BYTES (b byte index).
  - Multiplier inputs are a_reg byte i and b_reg byte j.
  - Each edge: acc <= acc + (P16 << 8*(i+j)).
  - acc is 16*N_BYTES wide; it is never exceeded, so no overflow handling.
  - After step N_BYTES^2-1, go to DONE.
- DONE:
  - out_valid=1; p driven from the acc register.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
  - While out_ready=0: p and out_valid hold stable (no glitch, no change).

Timing:
- Latency: out_valid rises exactly N_BYTES^2 cycles after the accept edge (4 cycles at default).
- Throughput: at most one result per N_BYTES^2+2 cycles.
- in_ready is low in MUL and DONE. in_valid there is ignored; operands are not sampled.
- A/B changing after acceptance has no effect.

Outputs and combinational paths:
- p is a registered output. Between results it holds the last product; at reset it is 0.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.
- The only combinational path is inside the shared multiplier, from the operand registers.

Other:
- in_valid and out_ready are sampled only in the states named above.
- X on a/b outside accept is harmless.

Decomposition:
Shared package:
- State enum: IDLE=2'd0, MUL=2'd1, DONE=2'd2.
- Localparams derived from N_BYTES: OP_W=8*N_BYTES, PR_W=16*N_BYTES, STEPS=N_BYTES*N_BYTES, CNT_W=max(1,clog2(STEPS)).

Sub-modules:
- One instance of the existing Multiplier8x8 (A, B, P) as the sole datapath sub-module.
- Byte-select muxes, shifter and accumulator live in mul_wide_sequencer.
- No other sub-module.

Test Plan:
1. Default N_BYTES=2: a=0x1234, b=0x5678, out_ready=1 -> out_valid rises 4 cycles after accept, p=0x06260060; busy high for 5 cycles; back in IDLE next cycle.
2. Max operands: a=0xFFFF, b=0xFFFF -> p=0xFFFE0001. Then zero operands a=0x0000, b=0xBEEF -> p=0x00000000.
3. Backpressure: a=0x00FF, b=0x0100, out_ready=0 for 10 cycles after out_valid -> p=0x0000FF00 held stable, in_ready=0 throughout. out_ready=1 -> single transfer, in_ready=1 next cycle.
4. Busy input ignored: during MUL drive in_valid=1, a=0xAAAA, b=0x5555 -> no second accept; first result unchanged. The second pair is accepted only once IDLE is re-entered.
5. Reset mid-op: assert rst_n=0 asynchronously at MUL step 2 -> out_valid=0, p=0, in_ready=1 immediately. After release, a=3, b=5 -> p=15.
6. N_BYTES=1 build: a=0xC8, b=0x64 -> p=0x4E20 after 1 MUL cycle. N_BYTES=4: a=0xFFFFFFFF, b=0x2 -> p=0x1FFFFFFFE after 16 cycles.

Source files
------------

// File: rtl/mul_wide_sequencer_pkg.sv
// Shared types and width helpers for the time-shared wide multiplier sequencer.
package mul_wide_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int op_width(input int n_bytes);
        return 8 * n_bytes;
    endfunction

    function automatic int pr_width(input int n_bytes);
        return 16 * n_bytes;
    endfunction

    function automatic int step_count(input int n_bytes);
        return n_bytes * n_bytes;
    endfunction

    // Keep the step counter at least one bit wide even when a single step suffices.
    function automatic int cnt_width(input int n_bytes);
        return (n_bytes * n_bytes > 1) ? $clog2(n_bytes * n_bytes) : 1;
    endfunction

endpackage

// File: rtl/Multiplier8x8.sv
// Unsigned 8x8 -> 16 combinational multiplier shared by the wide sequencer.
module Multiplier8x8 (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] P
);

    assign P = 16'(A) * 16'(B);

endmodule

// File: rtl/mul_wide_sequencer.sv
// Computes a (16*N_BYTES)-bit unsigned product one byte pair per cycle through
// a single 8x8 multiplier, behind valid/ready handshakes on both sides.
module mul_wide_sequencer
    import mul_wide_sequencer_pkg::*;
#(
    parameter int N_BYTES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*N_BYTES-1:0]   a,
    input  logic [8*N_BYTES-1:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [16*N_BYTES-1:0]  p,
    output logic                   busy
);

    localparam int OP_W  = op_width(N_BYTES);
    localparam int PR_W  = pr_width(N_BYTES);
    localparam int STEPS = step_count(N_BYTES);
    localparam int CNT_W = cnt_width(N_BYTES);

    state_e            state;
    state_e            state_next;
    logic [CNT_W-1:0]  step;
    logic [OP_W-1:0]   a_reg;
    logic [OP_W-1:0]   b_reg;
    logic [PR_W-1:0]   acc;
    logic [PR_W-1:0]   p_reg;

    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic [15:0]       mul_p;
    logic [PR_W-1:0]   term;
    logic [PR_W-1:0]   acc_next;
    logic              last_step;
    int                idx_a;
    int                idx_b;

    assign last_step = (step == CNT_W'(STEPS - 1));

    // Step s walks a-byte i = s / N_BYTES and b-byte j = s % N_BYTES.
    always_comb begin
        idx_a    = int'(step) / N_BYTES;
        idx_b    = int'(step) % N_BYTES;
        mul_a    = a_reg[8*idx_a +: 8];
        mul_b    = b_reg[8*idx_b +: 8];
        term     = PR_W'(mul_p) << (8 * (idx_a + idx_b));
        acc_next = acc + term;
    end

    Multiplier8x8 u_mul (
        .A (mul_a),
        .B (mul_b),
        .P (mul_p)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // in the block samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid)  state_next = MUL;
            MUL:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: operand, accumulator and result registers are all reset so an
    // aborted operation leaves nothing behind and p reads 0 out of reset.
    // p_reg is separate from acc so p keeps the last product while acc restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step  <= '0;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            p_reg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        step  <= '0;
                    end
                end
                MUL: begin
                    acc  <= acc_next;
                    step <= step + 1'b1;
                    if (last_step) begin
                        p_reg <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL) || (state == DONE);
    assign p         = p_reg;

endmodule

// File: tb/tb_mul_wide_sequencer.sv
// Self-checking bench: table-driven vectors through a result scoreboard on the
// default build, plus hand sequences for backpressure, busy input, reset and other widths.
module tb_mul_wide_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] a, b;
    logic [31:0] p;

    logic        iv1, ir1, ov1, or1, busy1;
    logic [7:0]  a1, b1;
    logic [15:0] p1;

    logic        iv4, ir4, ov4, or4, busy4;
    logic [31:0] a4, b4;
    logic [63:0] p4;

    mul_wide_sequencer #(.N_BYTES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
    );

    mul_wide_sequencer #(.N_BYTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1), .p(p1), .busy(busy1)
    );

    mul_wide_sequencer #(.N_BYTES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4)
    );

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic [31:0] exp_p;
        int          hold;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic accept(input logic [15:0] va, input logic [15:0] vb,
                          input logic [31:0] exp, input int hold);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        sb.push_back(exp);
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        check("busy_after_accept", busy, 1);
        check("in_ready_after_accept", in_ready, 0);
    endtask

    // Waits for the result, applies hold cycles of backpressure, then transfers.
    task automatic drain(input int hold);
        int          n;
        logic [31:0] exp_q;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            check("busy_in_mul", busy, 1);
            check("in_ready_in_mul", in_ready, 0);
        end
        check("out_valid_timeout", out_valid, 1);
        if (!out_valid) begin
            void'(sb.pop_front());
            return;
        end
        check("latency", n, 4);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_p", p, sb[0]);
        end
        out_ready = 1'b1;
        exp_q = sb.pop_front();
        check("p", p, exp_q);
        @(posedge clk);
        #1;
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
        check("post_p_held", p, exp_q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vecs[0] = '{16'h1234, 16'h5678, 32'h0626_0060, 0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0};
        vecs[2] = '{16'h0000, 16'hBEEF, 32'h0000_0000, 0};
        vecs[3] = '{16'h00FF, 16'h0100, 32'h0000_FF00, 10};
        vecs[4] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF, 2};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0;
        iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_p", p, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            accept(vecs[i].va, vecs[i].vb, vecs[i].exp_p, vecs[i].hold);
            drain(vecs[i].hold);
            out_ready = 1'b0;
        end

        // Operands offered while busy must wait for IDLE.
        accept(16'h0003, 16'h0007, 32'd21, 0);
        in_valid = 1'b1;
        a        = 16'hAAAA;
        b        = 16'h5555;
        drain(0);
        check("busy_pair_in_ready", in_ready, 1);
        sb.push_back(32'h38E3_1C72);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_pair_accepted", busy, 1);
        drain(0);

        // Asynchronous reset in MUL step 2 discards the operation.
        accept(16'h1234, 16'h5678, 32'h0, 0);
        void'(sb.pop_front());
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_p", p, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        accept(16'd3, 16'd5, 32'd15, 0);
        drain(0);

        // Single-byte build.
        @(negedge clk);
        iv1 = 1'b1; a1 = 8'hC8; b1 = 8'h64;
        @(posedge clk);
        #1;
        iv1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom);
        n = 0;
        while (!ov1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("n1_latency", n, 1);
        check("n1_p", p1, 16'h4E20);
        @(posedge clk);
        #1;
        check("n1_post_in_ready", ir1, 1);

        // Four-byte build.
        @(negedge clk);
        iv4 = 1'b1; a4 = 32'hFFFF_FFFF; b4 = 32'h2;
        @(posedge clk);
        #1;
        iv4 = 1'b0; a4 = $urandom; b4 = $urandom;
        n = 0;
        while (!ov4 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("n4_latency", n, 16);
        check("n4_p", p4, 64'h1_FFFF_FFFE);
        @(posedge clk);
        #1;
        check("n4_post_busy", busy4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
